// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: parity modes, minimum divisor and FSM encodings shared by the
// configurable UART core and its bit timer.
package uart_cfg_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int MIN_CLKS = 4;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: latches a clamped divisor on start, then ticks once per bit
// period; the first period may be a half period for mid-bit sampling.
module uart_bit_timer
  import uart_cfg_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             half,
  input  logic             early,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] per, cnt, div_c;
  assign div_c = (div < DIV_W'(MIN_CLKS)) ? DIV_W'(MIN_CLKS) : div;
  // early fires the tick one cycle ahead so a frame can end in the IDLE cycle
  assign tick = cnt == {{(DIV_W-1){1'b0}}, early};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      per <= DIV_W'(MIN_CLKS);
      cnt <= '0;
    end else if (start) begin
      per <= div_c;
      cnt <= (half ? div_c >> 1 : div_c) - DIV_W'(1);
    end else begin
      cnt <= tick ? per - DIV_W'(1) : cnt - DIV_W'(1);
    end
endmodule

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: full-duplex UART with configurable frame format, runtime
// divisor, valid/ready handshakes, framing/parity/overrun status and loopback.
module uart_core_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     i_clks_per_bit,
  input  logic                 i_loopback,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_active,
  output logic                 o_tx_done,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam bit HAS_PAR = PARITY != PAR_NONE;
  localparam bit ODD = PARITY == PAR_ODD;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t tx_st, tx_nxt;
  logic [DATA_BITS-1:0] tx_sh;
  logic [IW-1:0] tx_idx;
  logic tx_par, tx_line, tx_tick, tx_accept, tx_early, tx_done_q;

  assign tx_accept = i_tx_valid && tx_st == TX_IDLE;
  assign tx_early = tx_st == TX_STOP && tx_idx == LAST_STOP;
  assign tx_line = tx_st == TX_START ? 1'b0 :
                   tx_st == TX_DATA  ? tx_sh[0] :
                   tx_st == TX_PAR   ? tx_par : 1'b1;
  assign o_tx = tx_line | i_loopback;
  assign o_tx_ready = tx_st == TX_IDLE;
  assign o_tx_active = tx_st != TX_IDLE || tx_done_q;
  assign o_tx_done = tx_done_q;

  uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clk(clk), .reset(reset), .start(tx_accept), .half(1'b0),
    .early(tx_early), .div(i_clks_per_bit), .tick(tx_tick)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) tx_st <= TX_IDLE;
    else tx_st <= tx_nxt;

  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      TX_IDLE:  tx_nxt = i_tx_valid ? TX_START : TX_IDLE;
      TX_START: tx_nxt = tx_tick ? TX_DATA : TX_START;
      TX_DATA:  if (tx_tick && tx_idx == LAST_BIT) tx_nxt = HAS_PAR ? TX_PAR : TX_STOP;
      TX_PAR:   tx_nxt = tx_tick ? TX_STOP : TX_PAR;
      TX_STOP:  if (tx_tick && tx_idx == LAST_STOP) tx_nxt = TX_IDLE;
      default:  tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_sh <= '0;
      tx_idx <= '0;
      tx_par <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_st == TX_STOP && tx_nxt == TX_IDLE;
      if (tx_accept) begin
        tx_sh <= i_tx_data;
        tx_idx <= '0;
        tx_par <= ^i_tx_data ^ ODD;
      end else if (tx_tick && tx_st == TX_DATA) begin
        tx_sh <= tx_sh >> 1;
        tx_idx <= tx_idx == LAST_BIT ? '0 : tx_idx + IW'(1);
      end else if (tx_tick && tx_st == TX_STOP) begin
        tx_idx <= tx_idx + IW'(1);
      end
    end

  rx_state_t rx_st, rx_nxt;
  logic [1:0] rx_sync;
  logic [DATA_BITS-1:0] rx_sh;
  logic [IW-1:0] rx_idx;
  logic rx_s, rx_prev, rx_fall, rx_tick, rx_start, rx_done, rx_par;

  assign rx_s = rx_sync[1];
  assign rx_fall = rx_prev && !rx_s;
  assign rx_start = rx_st == RX_IDLE && rx_fall;
  assign rx_done = rx_st == RX_STOP && rx_tick;

  uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clk(clk), .reset(reset), .start(rx_start), .half(1'b1),
    .early(1'b0), .div(i_clks_per_bit), .tick(rx_tick)
  );

  // loopback source is selected ahead of the synchronizer so both paths share it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], i_loopback ? tx_line : i_rx};
      rx_prev <= rx_s;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_st <= RX_IDLE;
    else rx_st <= rx_nxt;

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE:  rx_nxt = rx_fall ? RX_START : RX_IDLE;
      RX_START: if (rx_tick) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == LAST_BIT) rx_nxt = HAS_PAR ? RX_PAR : RX_STOP;
      RX_PAR:   rx_nxt = rx_tick ? RX_STOP : RX_PAR;
      RX_STOP:  rx_nxt = rx_tick ? RX_IDLE : RX_STOP;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_sh <= '0;
      rx_idx <= '0;
      rx_par <= 1'b0;
      o_rx_data <= '0;
      o_rx_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= rx_done && o_rx_valid && !i_rx_ready;
      if (rx_start) rx_idx <= '0;
      if (rx_tick && rx_st == RX_DATA) begin
        rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
        rx_idx <= rx_idx + IW'(1);
      end
      if (rx_tick && rx_st == RX_PAR) rx_par <= rx_s;
      if (rx_done && (!o_rx_valid || i_rx_ready)) begin
        o_rx_data <= rx_sh;
        o_parity_err <= HAS_PAR && (^rx_sh ^ rx_par ^ ODD);
        o_frame_err <= !rx_s;
        o_rx_valid <= 1'b1;
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// tb_uart_core_cfg: scoreboard bench for uart_core_cfg (8 data bits, even
// parity, 1 stop bit) with directed scenarios and a randomized phase.
module tb_uart_core_cfg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] i_clks_per_bit = 16'd16;
  logic i_loopback = 1'b0;
  logic i_tx_valid = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic i_rx = 1'b1;
  logic i_rx_ready = 1'b1;
  logic o_tx_ready, o_tx, o_tx_active, o_tx_done;
  logic [7:0] o_rx_data;
  logic o_rx_valid, o_parity_err, o_frame_err, o_overrun;

  uart_core_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .i_clks_per_bit(i_clks_per_bit),
    .i_loopback(i_loopback), .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data),
    .o_tx_ready(o_tx_ready), .o_tx(o_tx), .o_tx_active(o_tx_active),
    .o_tx_done(o_tx_done), .i_rx(i_rx), .o_rx_data(o_rx_data),
    .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic pe; logic fe;} rx_t;
  rx_t rx_q[$];
  int tx_q[$];
  rx_t e;
  int total = 0, bad = 0, cyc = 0, lb_bad = 0, ovr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int neff();
    return i_clks_per_bit < 16'd4 ? 4 : int'(i_clks_per_bit);
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // monitor: frame timing, received frames and loopback line state
  always @(negedge clk)
    if (reset) begin
      if (i_loopback && !o_tx) lb_bad++;
      if (o_overrun) ovr_cnt++;
      if (o_tx_done) begin
        if (tx_q.size() == 0) chk("tx_done_unexpected", 1, 0);
        else chk("tx_done_cycle", cyc, tx_q.pop_front());
      end
      if (i_tx_valid && o_tx_ready) tx_q.push_back(cyc + 11 * neff());
      if (o_rx_valid && i_rx_ready) begin
        if (rx_q.size() == 0) chk("rx_valid_unexpected", 1, 0);
        else begin
          e = rx_q.pop_front();
          chk("rx_data", o_rx_data, e.d);
          chk("rx_parity_err", o_parity_err, e.pe);
          chk("rx_frame_err", o_frame_err, e.fe);
        end
      end
    end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_send(input logic [7:0] d, input bit keep, input bit push, output int c);
    int b;
    b = 0;
    c = -1;
    i_tx_data = d;
    i_tx_valid = 1'b1;
    while (c < 0 && b < 2000) begin
      if (o_tx_ready) c = cyc;
      step(1);
      b++;
    end
    if (c < 0) chk("tx_accept_timeout", 0, 1);
    else if (push) rx_q.push_back(rx_t'({d, 2'b00}));
    if (!keep) i_tx_valid = 1'b0;
  endtask

  task automatic send_ext(input logic [7:0] d, input bit flip, input bit stop);
    int n;
    logic [15:0] div_keep;
    n = neff();
    div_keep = i_clks_per_bit;
    rx_q.push_back(rx_t'({d, flip, ~stop}));
    i_rx = 1'b0;
    step(n);
    i_clks_per_bit = 16'($urandom_range(0, 40));
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      step(n);
    end
    i_rx = even_par(d) ^ flip;
    step(n);
    i_rx = stop;
    step(n);
    i_clks_per_bit = div_keep;
    i_rx = 1'b1;
    step(n);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((rx_q.size() > 0 || tx_q.size() > 0) && b < 5000) begin
      step(1);
      b++;
    end
    chk("drain_pending", rx_q.size() + tx_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, c1, c2;
    logic [7:0] d;
    step(3);
    chk("rst_tx", o_tx, 1);
    chk("rst_tx_ready", o_tx_ready, 1);
    chk("rst_tx_active", o_tx_active, 0);
    chk("rst_tx_done", o_tx_done, 0);
    chk("rst_rx_valid", o_rx_valid, 0);
    chk("rst_rx_data", o_rx_data, 0);
    chk("rst_errs", {o_parity_err, o_frame_err, o_overrun}, 0);
    reset = 1'b1;
    step(2);

    i_loopback = 1'b1;
    step(2);
    tx_send(8'hA5, 0, 1, c);
    wait_drain();

    i_loopback = 1'b0;
    step(2);
    send_ext(8'h3C, 1, 1);
    wait_drain();
    send_ext(8'h81, 0, 0);
    wait_drain();
    send_ext(8'h55, 0, 1);
    wait_drain();

    i_rx_ready = 1'b0;
    i_loopback = 1'b1;
    step(2);
    tx_send(8'h11, 0, 0, c);
    tx_send(8'h22, 0, 0, c);
    wait_drain();
    step(5);
    chk("hold_data", o_rx_data, 8'h11);
    chk("hold_valid", o_rx_valid, 1);
    chk("overrun_pulses", ovr_cnt, 1);
    rx_q.push_back(rx_t'({8'h11, 2'b00}));
    i_rx_ready = 1'b1;
    step(1);
    chk("valid_cleared", o_rx_valid, 0);
    chk("pop_scoreboard", rx_q.size(), 0);

    i_loopback = 1'b0;
    step(2);
    i_rx = 1'b0;
    step(6);
    i_rx = 1'b1;
    step(60);
    chk("glitch_valid", o_rx_valid, 0);
    chk("glitch_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
    send_ext(8'h5A, 0, 1);
    wait_drain();

    for (int it = 0; it < 12; it++) begin
      i_clks_per_bit = 16'($urandom_range(2, 24));
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        i_loopback = 1'b1;
        step(3);
        tx_send(d, 0, 1, c);
        step(12);
        i_clks_per_bit = 16'($urandom);
      end else begin
        i_loopback = 1'b0;
        step(3);
        send_ext(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      wait_drain();
    end

    i_clks_per_bit = 16'd16;
    i_loopback = 1'b0;
    step(3);
    tx_send(8'hF0, 1, 0, c1);
    tx_send(8'h0F, 0, 0, c2);
    chk("b2b_gap", c2 - c1, 176);
    chk("b2b_start_bit", o_tx, 0);
    step(68);
    reset = 1'b0;
    #1;
    tx_q.delete();
    chk("abort_tx_high", o_tx, 1);
    chk("abort_tx_ready", o_tx_ready, 1);
    chk("abort_tx_active", o_tx_active, 0);
    step(3);
    reset = 1'b1;
    step(2);
    chk("post_rst_ready", o_tx_ready, 1);
    chk("post_rst_rx_valid", o_rx_valid, 0);
    chk("post_rst_tx", o_tx, 1);

    chk("loopback_tx_low_cycles", lb_bad, 0);
    chk("overrun_total", ovr_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
